// File: rtl/lowx_mem_arbiter_pkg.sv
// Shared types and constants for the lowX memory-port arbiter.
// The icache and dcache miss paths share one main-memory port through this arbiter.
package lowx_mem_arbiter_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned BLK_SIZE = 128;

  localparam logic ARB_ID_I = 1'b0;
  localparam logic ARB_ID_D = 1'b1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait} arb_state_e;

  typedef struct packed {
    logic            valid;
    logic            ready;
    logic [XLEN-1:0] addr;
    logic            uncached;
  } ilowx_req_t;

  typedef struct packed {
    logic                valid;
    logic                ready;
    logic [BLK_SIZE-1:0] data;
  } ilowx_res_t;

  typedef struct packed {
    logic                valid;
    logic                ready;
    logic [XLEN-1:0]     addr;
    logic                rw;
    logic [1:0]          rw_type;
    logic [BLK_SIZE-1:0] data;
    logic                uncached;
  } dlowx_req_t;

  typedef struct packed {
    logic                valid;
    logic                ready;
    logic [BLK_SIZE-1:0] data;
  } dlowx_res_t;

  typedef struct packed {
    logic                valid;
    logic [XLEN-1:0]     addr;
    logic                rw;
    logic [1:0]          rw_type;
    logic [BLK_SIZE-1:0] data;
    logic                uncached;
    logic                id;
  } lowx_req_t;

  typedef struct packed {
    logic                valid;
    logic                ready;
    logic [BLK_SIZE-1:0] data;
  } lowx_res_t;

endpackage

// File: rtl/lowx_mem_arbiter_rr_arbiter2.sv
// Two-input round-robin picker: on a tie it grants whichever requester did not win last.
// The last winner is updated only when the owning transaction completes.
module lowx_mem_arbiter_rr_arbiter2
  import lowx_mem_arbiter_pkg::*;
#(
  parameter bit D_FIRST = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,       // bit 0 icache, bit 1 dcache
  input  logic       en_i,
  input  logic       update_i,
  input  logic       update_id_i,
  output logic       gnt_valid_o,
  output logic       gnt_id_o
);

  logic last_q;

  always_comb begin
    gnt_valid_o = en_i & (|req_i);
    unique case (req_i)
      2'b01:   gnt_id_o = ARB_ID_I;
      2'b10:   gnt_id_o = ARB_ID_D;
      2'b11:   gnt_id_o = ~last_q;
      default: gnt_id_o = ARB_ID_I;
    endcase
  end

  // Resetting to the opposite side makes D_FIRST the winner of the first tie.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q <= ~D_FIRST;
    end else if (update_i) begin
      last_q <= update_id_i;
    end
  end

endmodule

// File: rtl/lowx_mem_arbiter.sv
// Shares the single lowX memory port between icache and dcache miss paths.
// One transaction at a time; the response is routed back only to the granted requester.
module lowx_mem_arbiter
  import lowx_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = XLEN,
  parameter int unsigned LINE_W  = BLK_SIZE,
  parameter bit          D_FIRST = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  ilowx_req_t ilowx_req_i,
  output ilowx_res_t ilowx_res_o,
  input  dlowx_req_t dlowx_req_i,
  output dlowx_res_t dlowx_res_o,
  output lowx_req_t  lowx_req_o,
  input  lowx_res_t  lowx_res_i,
  output logic       busy_o
);

  arb_state_e state_q;
  lowx_req_t  req_q;

  logic              gnt_valid;
  logic              gnt_id;
  logic              done;
  logic [ADDR_W-1:0] gnt_addr;
  logic [LINE_W-1:0] gnt_data;
  logic              gnt_rw;
  logic [1:0]        gnt_rw_type;
  logic              gnt_uncached;

  // A response in ISSUE or WAIT completes the transaction; one in IDLE is dropped.
  assign done = (state_q != StIdle) & lowx_res_i.valid;

  lowx_mem_arbiter_rr_arbiter2 #(
    .D_FIRST (D_FIRST)
  ) u_rr (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_i       ({dlowx_req_i.valid, ilowx_req_i.valid}),
    .en_i        ((state_q == StIdle) & ~rst_i),
    .update_i    (done),
    .update_id_i (req_q.id),
    .gnt_valid_o (gnt_valid),
    .gnt_id_o    (gnt_id)
  );

  always_comb begin
    if (gnt_id == ARB_ID_D) begin
      gnt_addr     = dlowx_req_i.addr;
      gnt_data     = dlowx_req_i.data;
      gnt_rw       = dlowx_req_i.rw;
      gnt_rw_type  = dlowx_req_i.rw_type;
      gnt_uncached = dlowx_req_i.uncached;
    end else begin
      gnt_addr     = ilowx_req_i.addr;
      gnt_data     = '0;
      gnt_rw       = 1'b0;
      gnt_rw_type  = 2'b00;
      gnt_uncached = ilowx_req_i.uncached;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      req_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (gnt_valid) begin
            req_q   <= '{valid:    1'b1,
                         addr:     gnt_addr,
                         rw:       gnt_rw,
                         rw_type:  gnt_rw_type,
                         data:     gnt_data,
                         uncached: gnt_uncached,
                         id:       gnt_id};
            state_q <= StIssue;
          end
        end
        StIssue: begin
          if (lowx_res_i.valid) begin
            req_q.valid <= 1'b0;
            state_q     <= StIdle;
          end else if (lowx_res_i.ready) begin
            req_q.valid <= 1'b0;
            state_q     <= StWait;
          end
        end
        StWait: begin
          if (lowx_res_i.valid) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign lowx_req_o = req_q;
  assign busy_o     = (state_q != StIdle);

  always_comb begin
    ilowx_res_o = '0;
    dlowx_res_o = '0;
    if (done) begin
      if (req_q.id == ARB_ID_I) begin
        ilowx_res_o.valid = 1'b1;
        ilowx_res_o.data  = lowx_res_i.data;
      end else begin
        dlowx_res_o.valid = 1'b1;
        dlowx_res_o.data  = lowx_res_i.data;
      end
    end
    ilowx_res_o.ready = gnt_valid & (gnt_id == ARB_ID_I);
    dlowx_res_o.ready = gnt_valid & (gnt_id == ARB_ID_D);
  end

  logic unused_req_ready;
  assign unused_req_ready = ilowx_req_i.ready ^ dlowx_req_i.ready;

endmodule
